// File: rtl/uart_cfg_fifo.sv
// uart_cfg_fifo: UART core with a runtime-programmable baud tick, TX/RX
// serialisers (optional even/odd parity, 1 or 2 TX stop bits), a show-ahead
// FIFO in each direction and sticky parity/framing/overrun error flags.
//
// Ports:
//   i_clock, i_reset        rising-edge clock, asynchronous active-low reset
//   i_divisor               clocks per baud tick (0 and 1 both mean every clock)
//   i_parity_mode           00/11 none, 01 even, 10 odd
//   i_two_stop              two stop bits on TX
//   i_tx_wr, i_tx_data      push a byte into the TX FIFO
//   o_tx_full, o_tx_busy    TX FIFO full / TX FIFO non-empty or frame in flight
//   o_tx                    serial output (idles high)
//   i_rx                    serial input, asynchronous to i_clock
//   i_rx_rd                 pop the RX FIFO head
//   o_rx_data, o_rx_empty   RX FIFO head (show-ahead, 0 when empty) / empty
//   i_clr_err               clear all sticky error flags
//   o_parity_err, o_frame_err, o_overrun   sticky error flags
module uart_cfg_fifo #(
  parameter int unsigned N_BITS  = 8,
  parameter int unsigned N_TICKS = 16,
  parameter int unsigned NB_DIV  = 16,
  parameter int unsigned NB_ADDR = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [NB_DIV-1:0] i_divisor,
  input  logic [1:0]        i_parity_mode,
  input  logic              i_two_stop,
  input  logic              i_tx_wr,
  input  logic [N_BITS-1:0] i_tx_data,
  output logic              o_tx_full,
  output logic              o_tx_busy,
  output logic              o_tx,
  input  logic              i_rx,
  input  logic              i_rx_rd,
  output logic [N_BITS-1:0] o_rx_data,
  output logic              o_rx_empty,
  input  logic              i_clr_err,
  output logic              o_parity_err,
  output logic              o_frame_err,
  output logic              o_overrun
);

  localparam int unsigned DEPTH   = 1 << NB_ADDR;
  localparam int unsigned NB_TICK = $clog2(2 * N_TICKS);
  localparam int unsigned NB_BIT  = $clog2(N_BITS + 1);

  localparam logic [NB_TICK-1:0] TICK_LAST  = NB_TICK'(N_TICKS - 1);
  localparam logic [NB_TICK-1:0] TICK_LAST2 = NB_TICK'(2 * N_TICKS - 1);
  localparam logic [NB_TICK-1:0] TICK_HALF  = NB_TICK'(N_TICKS / 2 - 1);
  localparam logic [NB_BIT-1:0]  BIT_LAST   = NB_BIT'(N_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  // ---------------------------------------------------------------------------
  // Baud tick generator
  // ---------------------------------------------------------------------------
  logic [NB_DIV-1:0] baud_cnt;
  logic [NB_DIV-1:0] baud_last;
  logic              baud_tick;

  assign baud_last = (i_divisor > NB_DIV'(1)) ? i_divisor - NB_DIV'(1) : '0;
  // >= so that lowering the divisor while the counter is above the new max
  // still wraps instead of running the counter all the way round.
  assign baud_tick = (baud_cnt >= baud_last);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)       baud_cnt <= '0;
    else if (baud_tick) baud_cnt <= '0;
    else                baud_cnt <= baud_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [N_BITS-1:0]  tx_mem [DEPTH];
  logic [NB_ADDR:0]   tx_wr_ptr, tx_rd_ptr;
  logic               tx_empty, tx_full, tx_push, tx_pop;
  logic [N_BITS-1:0]  tx_head;

  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[NB_ADDR] != tx_rd_ptr[NB_ADDR]) &&
                    (tx_wr_ptr[NB_ADDR-1:0] == tx_rd_ptr[NB_ADDR-1:0]);
  assign tx_push  = i_tx_wr && (!tx_full || tx_pop);
  assign tx_head  = tx_mem[tx_rd_ptr[NB_ADDR-1:0]];

  always_ff @(posedge i_clock) begin
    if (tx_push) tx_mem[tx_wr_ptr[NB_ADDR-1:0]] <= i_tx_data;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  tx_state_t          tx_state, tx_state_nxt;
  logic [NB_TICK-1:0] tx_tick_cnt, tx_tick_nxt, tx_stop_last;
  logic [NB_BIT-1:0]  tx_bit_cnt, tx_bit_nxt;
  logic [N_BITS-1:0]  tx_shift, tx_shift_nxt;
  logic               tx_par_bit, tx_par_bit_nxt;
  logic               tx_par_en, tx_par_en_nxt;
  logic               tx_two_stop, tx_two_stop_nxt;
  logic               tx_line;

  assign tx_stop_last = tx_two_stop ? TICK_LAST2 : TICK_LAST;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tx_state    <= TX_IDLE;
      tx_tick_cnt <= '0;
      tx_bit_cnt  <= '0;
      tx_shift    <= '0;
      tx_par_bit  <= 1'b0;
      tx_par_en   <= 1'b0;
      tx_two_stop <= 1'b0;
    end else begin
      tx_state    <= tx_state_nxt;
      tx_tick_cnt <= tx_tick_nxt;
      tx_bit_cnt  <= tx_bit_nxt;
      tx_shift    <= tx_shift_nxt;
      tx_par_bit  <= tx_par_bit_nxt;
      tx_par_en   <= tx_par_en_nxt;
      tx_two_stop <= tx_two_stop_nxt;
    end
  end

  always_comb begin
    tx_state_nxt    = tx_state;
    tx_tick_nxt     = tx_tick_cnt;
    tx_bit_nxt      = tx_bit_cnt;
    tx_shift_nxt    = tx_shift;
    tx_par_bit_nxt  = tx_par_bit;
    tx_par_en_nxt   = tx_par_en;
    tx_two_stop_nxt = tx_two_stop;
    tx_pop          = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop          = 1'b1;
          tx_shift_nxt    = tx_head;
          // Parity bit and stop length are frozen for the whole frame here.
          tx_par_en_nxt   = ^i_parity_mode;
          tx_par_bit_nxt  = (^tx_head) ^ i_parity_mode[1];
          tx_two_stop_nxt = i_two_stop;
          tx_tick_nxt     = '0;
          tx_state_nxt    = TX_START;
        end
      end
      TX_START: begin
        if (baud_tick) begin
          if (tx_tick_cnt == TICK_LAST) begin
            tx_tick_nxt  = '0;
            tx_bit_nxt   = '0;
            tx_state_nxt = TX_DATA;
          end else begin
            tx_tick_nxt = tx_tick_cnt + 1'b1;
          end
        end
      end
      TX_DATA: begin
        if (baud_tick) begin
          if (tx_tick_cnt == TICK_LAST) begin
            tx_tick_nxt  = '0;
            tx_shift_nxt = tx_shift >> 1;
            if (tx_bit_cnt == BIT_LAST) tx_state_nxt = tx_par_en ? TX_PARITY : TX_STOP;
            else                        tx_bit_nxt   = tx_bit_cnt + 1'b1;
          end else begin
            tx_tick_nxt = tx_tick_cnt + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        if (baud_tick) begin
          if (tx_tick_cnt == TICK_LAST) begin
            tx_tick_nxt  = '0;
            tx_state_nxt = TX_STOP;
          end else begin
            tx_tick_nxt = tx_tick_cnt + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (baud_tick) begin
          if (tx_tick_cnt == tx_stop_last) begin
            tx_tick_nxt  = '0;
            tx_state_nxt = TX_IDLE;
          end else begin
            tx_tick_nxt = tx_tick_cnt + 1'b1;
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_line = 1'b1;
    unique case (tx_state)
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tx_shift[0];
      TX_PARITY: tx_line = tx_par_bit;
      default:   tx_line = 1'b1;
    endcase
  end

  assign o_tx      = tx_line;
  assign o_tx_full = tx_full;
  assign o_tx_busy = !tx_empty || (tx_state != TX_IDLE);

  // ---------------------------------------------------------------------------
  // RX synchroniser and FSM
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  rx_state_t          rx_state, rx_state_nxt;
  logic [NB_TICK-1:0] rx_tick_cnt, rx_tick_nxt;
  logic [NB_BIT-1:0]  rx_bit_cnt, rx_bit_nxt;
  logic [N_BITS-1:0]  rx_shift, rx_shift_nxt;
  logic               rx_par_bad, rx_par_bad_nxt;
  logic               rx_push_req, rx_set_frame, rx_set_par;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_state    <= RX_IDLE;
      rx_tick_cnt <= '0;
      rx_bit_cnt  <= '0;
      rx_shift    <= '0;
      rx_par_bad  <= 1'b0;
    end else begin
      rx_state    <= rx_state_nxt;
      rx_tick_cnt <= rx_tick_nxt;
      rx_bit_cnt  <= rx_bit_nxt;
      rx_shift    <= rx_shift_nxt;
      rx_par_bad  <= rx_par_bad_nxt;
    end
  end

  always_comb begin
    rx_state_nxt   = rx_state;
    rx_tick_nxt    = rx_tick_cnt;
    rx_bit_nxt     = rx_bit_cnt;
    rx_shift_nxt   = rx_shift;
    rx_par_bad_nxt = rx_par_bad;
    rx_push_req    = 1'b0;
    rx_set_frame   = 1'b0;
    rx_set_par     = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_tick_nxt    = '0;
          rx_par_bad_nxt = 1'b0;
          rx_state_nxt   = RX_START;
        end
      end
      RX_START: begin
        if (baud_tick) begin
          if (rx_tick_cnt == TICK_HALF) begin
            rx_tick_nxt  = '0;
            rx_bit_nxt   = '0;
            rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_tick_nxt = rx_tick_cnt + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (baud_tick) begin
          if (rx_tick_cnt == TICK_LAST) begin
            rx_tick_nxt  = '0;
            rx_shift_nxt = N_BITS'({rx_sync, rx_shift} >> 1);
            if (rx_bit_cnt == BIT_LAST) rx_state_nxt = (^i_parity_mode) ? RX_PARITY : RX_STOP;
            else                        rx_bit_nxt   = rx_bit_cnt + 1'b1;
          end else begin
            rx_tick_nxt = rx_tick_cnt + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (baud_tick) begin
          if (rx_tick_cnt == TICK_LAST) begin
            rx_tick_nxt    = '0;
            rx_par_bad_nxt = rx_sync != ((^rx_shift) ^ i_parity_mode[1]);
            rx_state_nxt   = RX_STOP;
          end else begin
            rx_tick_nxt = rx_tick_cnt + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (baud_tick) begin
          if (rx_tick_cnt == TICK_LAST) begin
            rx_tick_nxt  = '0;
            rx_state_nxt = RX_IDLE;
            if (!rx_sync) begin
              rx_set_frame = 1'b1;
            end else begin
              rx_push_req = 1'b1;
              rx_set_par  = rx_par_bad;
            end
          end else begin
            rx_tick_nxt = rx_tick_cnt + 1'b1;
          end
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [N_BITS-1:0] rx_mem [DEPTH];
  logic [NB_ADDR:0]  rx_wr_ptr, rx_rd_ptr;
  logic              rx_empty, rx_full, rx_push, rx_pop, rx_set_ovr;

  assign rx_empty   = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full    = (rx_wr_ptr[NB_ADDR] != rx_rd_ptr[NB_ADDR]) &&
                      (rx_wr_ptr[NB_ADDR-1:0] == rx_rd_ptr[NB_ADDR-1:0]);
  assign rx_pop     = i_rx_rd && !rx_empty;
  assign rx_push    = rx_push_req && (!rx_full || rx_pop);
  assign rx_set_ovr = rx_push_req && rx_full && !rx_pop;

  always_ff @(posedge i_clock) begin
    if (rx_push) rx_mem[rx_wr_ptr[NB_ADDR-1:0]] <= rx_shift;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
    end
  end

  // Masked so the head reads 0 whenever nothing valid is stored (incl. reset).
  assign o_rx_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr[NB_ADDR-1:0]];
  assign o_rx_empty = rx_empty;

  // ---------------------------------------------------------------------------
  // Sticky error flags: a set wins over a same-cycle clear
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (rx_set_par)     o_parity_err <= 1'b1;
      else if (i_clr_err) o_parity_err <= 1'b0;
      if (rx_set_frame)   o_frame_err  <= 1'b1;
      else if (i_clr_err) o_frame_err  <= 1'b0;
      if (rx_set_ovr)     o_overrun    <= 1'b1;
      else if (i_clr_err) o_overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cfg_fifo.sv
module tb_uart_cfg_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] divisor;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic        tx_full, tx_busy, tx_line;
  logic        rx_line, rx_drv, loop_en;
  logic        rx_rd;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic        clr_err;
  logic        parity_err, frame_err, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rx_line = loop_en ? tx_line : rx_drv;

  uart_cfg_fifo #(
    .N_BITS (8),
    .N_TICKS(16),
    .NB_DIV (16),
    .NB_ADDR(2)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_divisor    (divisor),
    .i_parity_mode(parity_mode),
    .i_two_stop   (two_stop),
    .i_tx_wr      (tx_wr),
    .i_tx_data    (tx_data),
    .o_tx_full    (tx_full),
    .o_tx_busy    (tx_busy),
    .o_tx         (tx_line),
    .i_rx         (rx_line),
    .i_rx_rd      (rx_rd),
    .o_rx_data    (rx_data),
    .o_rx_empty   (rx_empty),
    .i_clr_err    (clr_err),
    .o_parity_err (parity_err),
    .o_frame_err  (frame_err),
    .o_overrun    (overrun)
  );

  typedef struct {
    logic [15:0] div;
    logic [1:0]  tx_mode;
    logic [1:0]  rx_mode;
    logic        stop2;
    logic [7:0]  data;
    logic        exp_perr;
  } lb_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] d);
    tx_wr = 1'b1; tx_data = d;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic pop_rx();
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic wait_tx_start(input int budget);
    int k = 0;
    while (tx_line !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    check("tx_start_timeout", {31'd0, tx_line}, 32'd0);
  endtask

  task automatic wait_tx_idle(input int budget);
    int k = 0;
    while (tx_busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    check("tx_idle_timeout", {31'd0, tx_busy}, 32'd0);
  endtask

  task automatic wait_rx_avail(input int budget);
    int k = 0;
    while (rx_empty !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    check("rx_avail_timeout", {31'd0, rx_empty}, 32'd0);
  endtask

  // Bench-driven frame, no parity, divisor 2 (32 clocks per bit).
  task automatic send_frame(input logic [7:0] d, input int stop_len, input logic stop_lvl);
    rx_drv = 1'b0; clocks(32);
    for (int b = 0; b < 8; b++) begin rx_drv = d[b]; clocks(32); end
    rx_drv = stop_lvl; clocks(stop_len);
    rx_drv = 1'b1;
  endtask

  initial begin
    lb_vec_t    lb_tab[9];
    logic [7:0] b2b[4];
    logic [9:0] t1_bits;

    lb_tab[0] = '{16'd2, 2'b01, 2'b01, 1'b1, 8'hA5, 1'b0};
    lb_tab[1] = '{16'd2, 2'b01, 2'b01, 1'b1, 8'h3C, 1'b0};
    lb_tab[2] = '{16'd2, 2'b01, 2'b01, 1'b1, 8'hFF, 1'b0};
    lb_tab[3] = '{16'd2, 2'b01, 2'b01, 1'b1, 8'h00, 1'b0};
    lb_tab[4] = '{16'd2, 2'b10, 2'b01, 1'b0, 8'h01, 1'b1};
    lb_tab[5] = '{16'd0, 2'b10, 2'b10, 1'b0, 8'h01, 1'b0};
    lb_tab[6] = '{16'd1, 2'b00, 2'b00, 1'b1, 8'h7E, 1'b0};
    lb_tab[7] = '{16'd3, 2'b01, 2'b10, 1'b0, 8'h80, 1'b1};
    lb_tab[8] = '{16'd2, 2'b11, 2'b11, 1'b0, 8'hC4, 1'b0};
    b2b[0] = 8'hA5; b2b[1] = 8'h3C; b2b[2] = 8'hFF; b2b[3] = 8'h00;
    t1_bits = {1'b1, 8'hA5, 1'b0};

    rst_n = 1'b0; divisor = 16'd2; parity_mode = 2'b00; two_stop = 1'b0;
    tx_wr = 1'b0; tx_data = '0; rx_drv = 1'b1; loop_en = 1'b0;
    rx_rd = 1'b0; clr_err = 1'b0;

    // Reset state
    clocks(2);
    check("rst_tx",       {31'd0, tx_line},    32'd1);
    check("rst_tx_full",  {31'd0, tx_full},    32'd0);
    check("rst_tx_busy",  {31'd0, tx_busy},    32'd0);
    check("rst_rx_empty", {31'd0, rx_empty},   32'd1);
    check("rst_rx_data",  {24'd0, rx_data},    32'd0);
    check("rst_perr",     {31'd0, parity_err}, 32'd0);
    check("rst_ferr",     {31'd0, frame_err},  32'd0);
    check("rst_ovr",      {31'd0, overrun},    32'd0);
    rst_n = 1'b1;
    clocks(3);

    // 1: TX waveform of 0xA5, sampled at bit centres
    write_tx(8'hA5);
    check("t1_busy_after_wr", {31'd0, tx_busy}, 32'd1);
    wait_tx_start(20);
    clocks(16);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t1_bit%0d", i), {31'd0, tx_line}, {31'd0, t1_bits[i]});
      if (i < 9) clocks(32);
    end
    check("t1_busy_in_stop", {31'd0, tx_busy}, 32'd1);
    clocks(24);
    check("t1_busy_done", {31'd0, tx_busy}, 32'd0);
    check("t1_tx_idle",   {31'd0, tx_line}, 32'd1);

    // 2: back-to-back loopback, even parity, two stop bits
    loop_en = 1'b1; parity_mode = 2'b01; two_stop = 1'b1;
    for (int i = 0; i < 4; i++) write_tx(b2b[i]);
    wait_tx_idle(3000);
    clocks(4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_empty%0d", i), {31'd0, rx_empty}, 32'd0);
      check($sformatf("t2_data%0d", i),  {24'd0, rx_data},  {24'd0, b2b[i]});
      pop_rx();
    end
    check("t2_empty_end", {31'd0, rx_empty},   32'd1);
    check("t2_perr",      {31'd0, parity_err}, 32'd0);
    check("t2_ferr",      {31'd0, frame_err},  32'd0);
    check("t2_ovr",       {31'd0, overrun},    32'd0);

    // Table: single loopback frames over divisor/parity/stop combinations
    for (int r = 0; r < 9; r++) begin
      divisor = lb_tab[r].div; parity_mode = lb_tab[r].tx_mode; two_stop = lb_tab[r].stop2;
      write_tx(lb_tab[r].data);
      wait_tx_start(20);
      parity_mode = lb_tab[r].rx_mode;
      wait_rx_avail(3000);
      check($sformatf("lb%0d_data", r), {24'd0, rx_data},    {24'd0, lb_tab[r].data});
      check($sformatf("lb%0d_perr", r), {31'd0, parity_err}, {31'd0, lb_tab[r].exp_perr});
      check($sformatf("lb%0d_ferr", r), {31'd0, frame_err},  32'd0);
      pop_rx();
      wait_tx_idle(3000);
      check($sformatf("lb%0d_empty", r), {31'd0, rx_empty}, 32'd1);
      pulse_clr();
      check($sformatf("lb%0d_perr_clr", r), {31'd0, parity_err}, 32'd0);
    end

    // 4: five frames plus a write into a full TX FIFO, no reads -> overrun
    divisor = 16'd2; parity_mode = 2'b00; two_stop = 1'b0;
    for (int i = 0; i < 5; i++) write_tx(8'h11 + 8'(i));
    check("t4_tx_full", {31'd0, tx_full}, 32'd1);
    write_tx(8'h99);
    check("t4_tx_full_drop", {31'd0, tx_full}, 32'd1);
    wait_tx_idle(4000);
    clocks(4);
    check("t4_ovr", {31'd0, overrun}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_data%0d", i), {24'd0, rx_data}, 32'h11 + 32'(i));
      pop_rx();
    end
    check("t4_empty", {31'd0, rx_empty}, 32'd1);
    pulse_clr();
    check("t4_ovr_clr", {31'd0, overrun}, 32'd1 - 32'd1);

    // 5: stop bit 0, then a 4-tick glitch, then a good frame
    loop_en = 1'b0;
    send_frame(8'h5A, 24, 1'b0);
    clocks(100);
    check("t5_ferr",  {31'd0, frame_err}, 32'd1);
    check("t5_empty", {31'd0, rx_empty},  32'd1);
    rx_drv = 1'b0; clocks(8); rx_drv = 1'b1;
    clocks(100);
    check("t5_glitch_empty", {31'd0, rx_empty},   32'd1);
    check("t5_glitch_perr",  {31'd0, parity_err}, 32'd0);
    send_frame(8'h5A, 32, 1'b1);
    wait_rx_avail(100);
    check("t5_good_data", {24'd0, rx_data}, 32'h5A);
    pop_rx();

    // 6: reset mid-DATA on both TX and RX (frame_err is still sticky here)
    loop_en = 1'b1;
    write_tx(8'hC3);
    wait_tx_start(20);
    clocks(16 + 32 * 3);
    check("t6_busy_pre", {31'd0, tx_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_tx_now",  {31'd0, tx_line},   32'd1);
    check("t6_busy",    {31'd0, tx_busy},   32'd0);
    check("t6_full",    {31'd0, tx_full},   32'd0);
    check("t6_rx_empty",{31'd0, rx_empty},  32'd1);
    check("t6_ferr",    {31'd0, frame_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clocks(500);
    check("t6_no_partial", {31'd0, rx_empty}, 32'd1);
    check("t6_idle",       {31'd0, tx_busy},  32'd0);
    pop_rx();
    check("t6_rd_empty", {31'd0, rx_empty}, 32'd1);
    write_tx(8'h96);
    wait_rx_avail(1000);
    check("t6_data", {24'd0, rx_data}, 32'h96);
    pop_rx();
    check("t6_empty_end", {31'd0, rx_empty}, 32'd1);
    wait_tx_idle(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
